// File: rtl/psum_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : psum_accumulator                                             |
// | Description : Multi-channel signed partial-sum accumulator. Sums CH        |
// |               products per beat over a window of cfg_len beats and holds   |
// |               the narrowed results on a valid/ready output register.       |
// |               Optional saturation with per-channel overflow flags.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module psum_accumulator #(
  parameter int CH     = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int LEN_W  = 8,
  parameter int SAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*DATA_W-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic [CH-1:0]         out_ovf,
  output logic                  busy
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Window control
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_first;
  logic [LEN_W-1:0] len_eff;
  logic             first;
  logic             last;
  logic             fire;
  logic             out_valid_q;

  // The window length is taken live from cfg_len only on the first beat;
  // afterwards the captured copy governs so mid-window edits are ignored.
  assign first     = (cnt == '0);
  assign len_first = (cfg_len == '0) ? LEN_ONE : cfg_len;
  assign len_eff   = first ? len_first : len_q;
  assign last      = (cnt == (len_eff - LEN_ONE));

  // Only the completing beat needs the output register free; earlier beats
  // keep accumulating while a previous result is still held.
  assign in_ready  = !(last && out_valid_q && !out_ready);
  assign fire      = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign busy      = (cnt != '0);

  // Beat counter, captured window length and output-valid handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      cnt         <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (fire) begin
        if (first) begin
          len_q <= len_first;
        end
        cnt <= last ? '0 : (cnt + LEN_ONE);
      end
      // A completing window on the transfer edge keeps valid high back-to-back
      if (fire && last) begin
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Per-channel datapath
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DATA_W-1:0] din;
    logic signed [ACC_W-1:0]  din_x;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W:0]    sum;
    logic                     beat_ovf;
    logic                     ovf_r;
    logic                     narrow_ovf;
    logic [OUT_W-1:0]         out_nxt;
    logic [OUT_W-1:0]         out_r;
    logic                     oovf_r;

    assign din   = in_data[c*DATA_W +: DATA_W];
    assign din_x = ACC_W'(din);
    // One extra bit of headroom makes signed overflow visible as a mismatch
    // between the two top bits.
    assign sum   = (ACC_W+1)'(acc_r) + (ACC_W+1)'(din_x);

    // Next accumulator value: load on the first beat, else add with clamp/wrap
    always_comb begin
      acc_nxt  = din_x;
      beat_ovf = 1'b0;
      if (!first) begin
        acc_nxt = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          beat_ovf = 1'b1;
          if (SAT != 0) begin
            acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
          end
        end
      end
    end

    if (OUT_W < ACC_W) begin : g_narrow
      logic [ACC_W-OUT_W:0] top;
      logic                 fits;
      // The value fits OUT_W when every bit above the output sign bit
      // repeats that sign bit.
      assign top        = acc_nxt[ACC_W-1:OUT_W-1];
      assign fits       = (&top) | ~(|top);
      assign narrow_ovf = !fits;
      assign out_nxt    = (fits || (SAT == 0)) ? acc_nxt[OUT_W-1:0]
                        : (acc_nxt[ACC_W-1] ? OUT_MIN : OUT_MAX);
    end else begin : g_full
      assign narrow_ovf = 1'b0;
      assign out_nxt    = acc_nxt[OUT_W-1:0];
    end

    // Accumulator, sticky window overflow and held result for this channel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_r  <= '0;
        ovf_r  <= 1'b0;
        out_r  <= '0;
        oovf_r <= 1'b0;
      end else if (clear) begin
        acc_r  <= '0;
        ovf_r  <= 1'b0;
        out_r  <= '0;
        oovf_r <= 1'b0;
      end else if (fire) begin
        acc_r <= acc_nxt;
        ovf_r <= first ? 1'b0 : (ovf_r | beat_ovf);
        if (last) begin
          out_r  <= out_nxt;
          // The sticky flag still belongs to the previous window on a first beat
          oovf_r <= (first ? 1'b0 : ovf_r) | beat_ovf | narrow_ovf;
        end
      end
    end

    assign out_data[c*OUT_W +: OUT_W] = out_r;
    assign out_ovf[c]                 = oovf_r;
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_psum_accumulator                                          |
// | Description : Directed self-checking bench for psum_accumulator            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_psum_accumulator;

  localparam int CH     = 4;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 32;
  localparam int LEN_W  = 8;
  localparam int SAT    = 1;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 clear     = 1'b0;
  logic [LEN_W-1:0]     cfg_len   = '0;
  logic                 in_valid  = 1'b0;
  logic [CH*DATA_W-1:0] in_data   = '0;
  logic                 out_ready = 1'b0;
  logic                 in_ready;
  logic                 out_valid;
  logic [CH*OUT_W-1:0]  out_data;
  logic [CH-1:0]        out_ovf;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  psum_accumulator #(
    .CH(CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .LEN_W(LEN_W), .SAT(SAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pk4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  // channel c carries v*(c+1)
  function automatic logic [127:0] pks(input int v);
    return pk4(v, 2*v, 3*v, 4*v);
  endfunction

  // present one beat across one rising edge, then sample 1 time unit later
  task automatic beat(input logic [127:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid act=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data act=%h exp=0", out_data); end
    total++; if (out_ovf !== 4'b0000) begin bad++; $display("FAIL reset_ovf act=%b exp=0000", out_ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy act=%b exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready act=%b exp=1", in_ready); end
  endtask

  task automatic test_basic_window();
    out_ready = 1'b1;
    cfg_len   = 8'd3;
    beat(pks(1));
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy act=%b exp=1", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid act=%b exp=0", out_valid); end
    beat(pks(2));
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_mid_valid act=%b exp=0", out_valid); end
    beat(pks(3));
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid act=%b exp=1", out_valid); end
    total++; if (out_data !== pk4(6, 12, 18, 24)) begin bad++; $display("FAIL basic_data act=%h exp=%h", out_data, pk4(6, 12, 18, 24)); end
    total++; if (out_ovf !== 4'b0000) begin bad++; $display("FAIL basic_ovf act=%b exp=0000", out_ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end act=%b exp=0", busy); end
    idle_cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain act=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    cfg_len   = 8'd2;
    beat(pks(1));
    beat(pks(2));
    total++; if (out_data !== pks(3)) begin bad++; $display("FAIL bp_first_data act=%h exp=%h", out_data, pks(3)); end
    beat(pks(4));
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy act=%b exp=1", busy); end
    in_valid = 1'b1;
    in_data  = pks(5);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall act=%b exp=0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_hold act=%b exp=0", in_ready); end
      total++; if (out_data !== pks(3) || out_valid !== 1'b1) begin bad++; $display("FAIL bp_held_data act=%h/%b exp=%h/1", out_data, out_valid, pks(3)); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release act=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_b2b_valid act=%b exp=1", out_valid); end
    total++; if (out_data !== pks(9)) begin bad++; $display("FAIL bp_second_data act=%h exp=%h", out_data, pks(9)); end
    idle_cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain act=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    cfg_len   = 8'd2;
    beat(pk4(32'h7FFF_FFFF, -1, 1, 1));
    beat(pk4(32'h7FFF_FFFF, -2, 1, 1));
    total++; if (out_data !== pk4(32'h7FFF_FFFF, -3, 2, 2)) begin bad++; $display("FAIL sat_data act=%h exp=%h", out_data, pk4(32'h7FFF_FFFF, -3, 2, 2)); end
    total++; if (out_ovf !== 4'b0001) begin bad++; $display("FAIL sat_ovf act=%b exp=0001", out_ovf); end
    idle_cycle();
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    cfg_len   = 8'd0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = pks(10 + i);
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_data !== pks(10 + i)) begin bad++; $display("FAIL single_beat_%0d act=%h/%b exp=%h/1", i, out_data, out_valid, pks(10 + i)); end
      total++; if (out_ovf !== 4'b0000) begin bad++; $display("FAIL single_ovf_%0d act=%b exp=0000", i, out_ovf); end
    end
    in_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy act=%b exp=0", busy); end
    idle_cycle();
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    cfg_len   = 8'd1;
    beat(pks(50));
    cfg_len   = 8'd4;
    beat(pks(1));
    beat(pks(2));
    total++; if (busy !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL clear_pre act=%b/%b exp=1/1", busy, out_valid); end
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = pks(100);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_valid act=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy act=%b exp=0", busy); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL clear_data act=%h exp=0", out_data); end
    out_ready = 1'b1;
    cfg_len   = 8'd2;
    beat(pk4(5, 5, 5, 5));
    beat(pk4(7, 7, 7, 7));
    total++; if (out_valid !== 1'b1 || out_data !== pk4(12, 12, 12, 12)) begin bad++; $display("FAIL clear_new_window act=%h/%b exp=%h/1", out_data, out_valid, pk4(12, 12, 12, 12)); end
    idle_cycle();
  endtask

  task automatic test_async_reset_and_len();
    out_ready = 1'b0;
    cfg_len   = 8'd1;
    beat(pks(9));
    cfg_len   = 8'd3;
    beat(pks(1));
    cfg_len   = 8'd1;
    in_valid  = 1'b1;
    in_data   = pks(2);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL len_ignored_ready act=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1 || out_data !== pks(9)) begin bad++; $display("FAIL len_ignored_state act=%b/%h exp=1/%h", busy, out_data, pks(9)); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid act=%b exp=0", out_valid); end
    total++; if (out_data !== '0 || out_ovf !== 4'b0000) begin bad++; $display("FAIL arst_data act=%h/%b exp=0/0000", out_data, out_ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy act=%b exp=0", busy); end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cfg_len   = 8'd3;
    beat(pks(1));
    cfg_len   = 8'd1;
    beat(pks(2));
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL len_change_early act=%b exp=0", out_valid); end
    beat(pks(3));
    total++; if (out_valid !== 1'b1 || out_data !== pks(6)) begin bad++; $display("FAIL len_change_sum act=%h/%b exp=%h/1", out_data, out_valid, pks(6)); end
    idle_cycle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic_window();
    test_backpressure();
    test_saturation();
    test_single_beat();
    test_clear();
    test_async_reset_and_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
